pcd_pause_n_generator: RTL and testbench



---
 rtl/pcd_pause_n_generator.sv | 122 ++++++++++++
 tb/tb_pcd_pause_n_generator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pcd_pause_n_generator.sv
// pcd_pause_n_generator: Modified Miller encoder for ISO 14443A PCD at 106 kbit/s.
// It turns SOC/0/1/EOC symbols into the carrier-pause envelope pause_n. One clk cycle is one fc.
module pcd_pause_n_generator #(
   parameter int BIT_PERIOD_FC = 128,
   parameter int PAUSE_LEN_FC  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] in_sym,
   output logic       in_ready,
   output logic       pause_n,
   output logic       busy,
   output logic       underflow,
   output logic       error
);
   localparam int CW   = $clog2(BIT_PERIOD_FC);
   localparam int HALF = BIT_PERIOD_FC / 2;
   localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD_FC - 1);
   localparam logic [1:0] SYM_0 = 2'd0, SYM_1 = 2'd1, SYM_SOC = 2'd2, SYM_EOC = 2'd3;

   if (BIT_PERIOD_FC % 2 != 0 || BIT_PERIOD_FC < 8 || PAUSE_LEN_FC < 1 || PAUSE_LEN_FC >= HALF) begin : g_param_chk
      $fatal(1, "pcd_pause_n_generator: illegal BIT_PERIOD_FC/PAUSE_LEN_FC");
   end

   typedef enum logic [1:0] {IDLE, BIT, EOC_Y} state_t;
   typedef enum logic [1:0] {SEQ_Y, SEQ_Z, SEQ_X} seq_t;

   state_t state, state_n;
   seq_t seq, seq_n;
   logic [CW-1:0] cnt, cnt_n;
   logic prev_zero, pz_n, eoc_pend, eoc_n, busy_n, uf_n, err_n, pn_n, acc, last;

   function automatic logic pause_val(seq_t s, logic [CW-1:0] c);
      int ci;
      ci = int'(c);
      return !((s == SEQ_Z && ci < PAUSE_LEN_FC) ||
               (s == SEQ_X && ci >= HALF && ci < HALF + PAUSE_LEN_FC));
   endfunction

   assign last     = cnt == LAST;
   assign in_ready = state == IDLE || (state == BIT && last && !eoc_pend);
   assign acc      = in_valid && in_ready;

   always_comb begin
      state_n = state;
      seq_n   = seq;
      cnt_n   = (state == IDLE || last) ? cnt : cnt + 1'b1;
      pz_n    = prev_zero;
      eoc_n   = eoc_pend;
      busy_n  = busy;
      uf_n    = 1'b0;
      err_n   = 1'b0;
      if (state == IDLE) begin
         if (acc && in_sym == SYM_SOC) begin
            state_n = BIT;
            seq_n   = SEQ_Z;
            cnt_n   = '0;
            pz_n    = 1'b1;
            eoc_n   = 1'b0;
            busy_n  = 1'b1;
         end else if (acc) begin
            err_n = 1'b1;
         end
      end else if (state == BIT && last) begin
         cnt_n = '0;
         if (eoc_pend) begin
            // the EOC's logic 0 has just finished; one trailing Y period follows
            state_n = EOC_Y;
            seq_n   = SEQ_Y;
            eoc_n   = 1'b0;
         end else if (!acc) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            uf_n    = 1'b1;
         end else if (in_sym == SYM_SOC) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            err_n   = 1'b1;
         end else if (in_sym == SYM_1) begin
            seq_n = SEQ_X;
            pz_n  = 1'b0;
         end else begin
            seq_n = prev_zero ? SEQ_Z : SEQ_Y;
            pz_n  = 1'b1;
            eoc_n = in_sym == SYM_EOC;
         end
      end else if (state == EOC_Y && last) begin
         state_n = IDLE;
         cnt_n   = '0;
         busy_n  = 1'b0;
      end
      pn_n = (state_n == BIT) ? pause_val(seq_n, cnt_n) : 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         seq       <= SEQ_Y;
         cnt       <= '0;
         prev_zero <= 1'b0;
         eoc_pend  <= 1'b0;
         pause_n   <= 1'b1;
         busy      <= 1'b0;
         underflow <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         seq       <= seq_n;
         cnt       <= cnt_n;
         prev_zero <= pz_n;
         eoc_pend  <= eoc_n;
         pause_n   <= pn_n;
         busy      <= busy_n;
         underflow <= uf_n;
         error     <= err_n;
      end
   end

   logic unused_sym0;
   assign unused_sym0 = SYM_0 == 2'd0;
endmodule

// File: tb/tb_pcd_pause_n_generator.sv
// tb_pcd_pause_n_generator: directed bench for the Modified Miller pause_n encoder.
// t=0 is the SOC acceptance edge; outputs are sampled 1 ns after each rising edge.
module tb_pcd_pause_n_generator;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
   logic [1:0] in_sym = 2'd0;
   logic in_ready, pause_n, busy, underflow, error;
   int errors = 0, checks = 0;

   localparam logic [1:0] S0 = 2'd0, S1 = 2'd1, SOC = 2'd2, EOC = 2'd3;

   pcd_pause_n_generator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
      .in_ready(in_ready), .pause_n(pause_n), .busy(busy),
      .underflow(underflow), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int t, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present SOC so that the next edge is t=0
   task automatic start_soc();
      in_valid = 1'b1;
      in_sym   = SOC;
      step();
   endtask

   // symbols are offered exactly on the 128-fc boundaries; pauses are hand-listed start times
   task automatic run_frame(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3,
                            input logic [1:0] s4, input int n, input int p0, input int p1,
                            input int p2, input int p3, input int bend);
      logic [1:0] syms [0:4];
      syms[0] = SOC; syms[1] = s1; syms[2] = s2; syms[3] = s3; syms[4] = s4;
      start_soc();
      for (int t = 0; t <= bend + 2; t++) begin
         logic ep;
         ep = !((t >= p0 && t < p0 + 32) || (t >= p1 && t < p1 + 32) ||
                (t >= p2 && t < p2 + 32) || (t >= p3 && t < p3 + 32));
         chk("pause_n", t, pause_n, ep);
         chk("busy", t, busy, t < bend);
         chk("in_ready", t, in_ready, (t % 128 == 127 && t < (n - 1) * 128) || t >= bend);
         chk("uf_err", t, underflow | error, 1'b0);
         if ((t + 1) % 128 == 0 && (t + 1) / 128 < n) begin
            in_valid = 1'b1;
            in_sym   = syms[(t + 1) / 128];
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
   endtask

   initial begin
      repeat (3) step();
      chk("rst_pause_n", 0, pause_n, 1'b1);
      chk("rst_in_ready", 0, in_ready, 1'b1);
      chk("rst_busy", 0, busy, 1'b0);
      chk("rst_underflow", 0, underflow, 1'b0);
      chk("rst_error", 0, error, 1'b0);
      rst_n = 1'b1;
      step();

      // SOC,1,0,0,EOC
      run_frame(S1, S0, S0, EOC, 5, 0, 192, 384, 512, 768);
      // SOC,0,EOC
      run_frame(S0, EOC, S0, S0, 3, 0, 128, 256, -1000, 512);

      // underflow after SOC
      start_soc();
      in_valid = 1'b0;
      repeat (127) step();
      chk("uf_ready127", 127, in_ready, 1'b1);
      chk("uf_busy127", 127, busy, 1'b1);
      chk("uf_pulse_early", 127, underflow, 1'b0);
      step();
      chk("uf_pulse", 128, underflow, 1'b1);
      chk("uf_busy", 128, busy, 1'b0);
      chk("uf_pause_n", 128, pause_n, 1'b1);
      chk("uf_ready", 128, in_ready, 1'b1);
      chk("uf_no_err", 128, error, 1'b0);
      step();
      chk("uf_pulse_end", 129, underflow, 1'b0);

      // logic 1 in IDLE
      in_valid = 1'b1;
      in_sym   = S1;
      step();
      in_valid = 1'b0;
      chk("idle1_err", 0, error, 1'b1);
      chk("idle1_pause_n", 0, pause_n, 1'b1);
      chk("idle1_busy", 0, busy, 1'b0);
      chk("idle1_ready", 0, in_ready, 1'b1);
      step();
      chk("idle1_err_end", 1, error, 1'b0);

      // SOC mid-frame at the boundary
      start_soc();
      in_valid = 1'b0;
      repeat (127) step();
      in_valid = 1'b1;
      in_sym   = SOC;
      step();
      in_valid = 1'b0;
      chk("soc_mid_err", 128, error, 1'b1);
      chk("soc_mid_busy", 128, busy, 1'b0);
      chk("soc_mid_pause_n", 128, pause_n, 1'b1);
      chk("soc_mid_ready", 128, in_ready, 1'b1);
      chk("soc_mid_uf", 128, underflow, 1'b0);
      step();
      chk("soc_mid_err_end", 129, error, 1'b0);

      // reset during the SOC pause
      start_soc();
      in_valid = 1'b0;
      repeat (10) step();
      chk("rst_mid_pre", 10, pause_n, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_pause_n", 10, pause_n, 1'b1);
      chk("rst_mid_busy", 10, busy, 1'b0);
      chk("rst_mid_ready", 10, in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      step();
      run_frame(S0, EOC, S0, S0, 3, 0, 128, 256, -1000, 512);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
